// File: rtl/spi_sram_23lc512.sv
// Serial SPI SRAM slave model: 23LC512 instruction subset, single-bit SPI mode 0.
// Inputs are sampled on SCK rise; SO_SIO1 changes on SCK fall.
// CS_N high asynchronously returns the transaction logic to IDLE.
// The mode register and the memory array are not affected by CS_N.
// HOLD_N_SIO3 low freezes all transaction state and floats SO_SIO1.
// dbg_state and so_en expose the FSM state and the output enable for observation.
module spi_sram_23lc512 #(
  parameter int         ADDR_W     = 16,
  parameter int         PAGE_BYTES = 32,
  parameter logic [7:0] MODE_RST   = 8'h40
) (
  input  logic       SCK,
  input  logic       RESET,
  input  logic       CS_N,
  input  logic       SI_SIO0,
  output logic       SO_SIO1,
  input  logic       HOLD_N_SIO3,
  output logic [2:0] dbg_state,
  output logic       so_en
);

  localparam int PAGE_W    = $clog2(PAGE_BYTES);
  localparam int CNT_W     = $clog2(ADDR_W + 9);
  localparam int MEM_DEPTH = 1 << ADDR_W;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDMR  = 8'h05;
  localparam logic [7:0] OP_WRMR  = 8'h01;

  localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST_BIT  = CNT_W'(7);
  localparam logic [CNT_W-1:0]  CNT_MODE_DONE = CNT_W'(8);
  localparam logic [CNT_W-1:0]  CNT_LAST_ADDR = CNT_W'(ADDR_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE      = ADDR_W'(1);
  localparam logic [PAGE_W-1:0] PAGE_ONE      = PAGE_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_MODEW,
    ST_MODER,
    ST_IGNORE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [7:0]         shift_sr, shift_n;
  logic [7:0]         shift_in;
  logic [ADDR_W-1:0]  addr, addr_n;
  logic [ADDR_W-1:0]  adv_addr;
  logic [PAGE_W-1:0]  page_inc;
  logic               is_read, is_read_n;
  logic               mem_we;
  logic               mode_we;
  logic [7:0]         mode;
  logic [7:0]         mem [MEM_DEPTH];
  logic               drive;
  logic               so_bit;
  logic [2:0]         bit_sel;
  logic               out_state;

  assign shift_in  = {shift_sr[6:0], SI_SIO0};
  assign page_inc  = addr[PAGE_W-1:0] + PAGE_ONE;
  // Bit counter 0..7 maps to data bit 7..0 (MSB first).
  assign bit_sel   = ~cnt[2:0];
  assign out_state = (state == ST_RDATA) || (state == ST_MODER);
  assign dbg_state = state;

  // Next address after a completed byte, chosen by mode register bits [7:6].
  always_comb begin
    adv_addr = addr;
    case (mode[7:6])
      2'b01:   adv_addr = addr + ADDR_ONE;
      2'b10:   adv_addr = {addr[ADDR_W-1:PAGE_W], page_inc};
      default: adv_addr = addr;
    endcase
  end

  // Next-state and datapath decode for one sampled SCK rise.
  // The state register is only out of IDLE while CS_N is low, so IDLE
  // advancing unconditionally is correct: CS_N high holds it in clear.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shift_n   = shift_sr;
    addr_n    = addr;
    is_read_n = is_read;
    mem_we    = 1'b0;
    mode_we   = 1'b0;
    case (state)
      ST_IDLE: begin
        // The first rise after selection already carries command bit 7.
        state_n = ST_CMD;
        shift_n = shift_in;
        cnt_n   = CNT_ONE;
      end
      ST_CMD: begin
        shift_n = shift_in;
        cnt_n   = cnt + CNT_ONE;
        if (cnt == CNT_LAST_BIT) begin
          cnt_n = '0;
          case (shift_in)
            OP_READ: begin
              state_n   = ST_ADDR;
              is_read_n = 1'b1;
            end
            OP_WRITE: begin
              state_n   = ST_ADDR;
              is_read_n = 1'b0;
            end
            OP_RDMR: state_n = ST_MODER;
            OP_WRMR: state_n = ST_MODEW;
            // RSTIO (8'hFF) is a no-op in single-bit mode; it lands here too.
            default: state_n = ST_IGNORE;
          endcase
        end
      end
      ST_ADDR: begin
        addr_n = {addr[ADDR_W-2:0], SI_SIO0};
        cnt_n  = cnt + CNT_ONE;
        if (cnt == CNT_LAST_ADDR) begin
          cnt_n   = '0;
          state_n = is_read ? ST_RDATA : ST_WDATA;
        end
      end
      ST_WDATA: begin
        shift_n = shift_in;
        cnt_n   = cnt + CNT_ONE;
        if (cnt == CNT_LAST_BIT) begin
          cnt_n  = '0;
          mem_we = 1'b1;
          addr_n = adv_addr;
        end
      end
      ST_RDATA: begin
        cnt_n = cnt + CNT_ONE;
        if (cnt == CNT_LAST_BIT) begin
          cnt_n  = '0;
          addr_n = adv_addr;
        end
      end
      ST_MODEW: begin
        // Counter parks at 8 so trailing bits are ignored.
        if (cnt != CNT_MODE_DONE) begin
          shift_n = shift_in;
          cnt_n   = cnt + CNT_ONE;
          if (cnt == CNT_LAST_BIT) begin
            mode_we = 1'b1;
          end
        end
      end
      ST_MODER: begin
        cnt_n = (cnt == CNT_LAST_BIT) ? '0 : cnt + CNT_ONE;
      end
      ST_IGNORE: begin
        state_n = ST_IGNORE;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Transaction state register: CS_N high clears asynchronously, RESET synchronously, HOLD freezes.
  always_ff @(posedge SCK or posedge CS_N) begin
    if (CS_N) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shift_sr <= '0;
      addr     <= '0;
      is_read  <= 1'b0;
    end else if (RESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shift_sr <= '0;
      addr     <= '0;
      is_read  <= 1'b0;
    end else if (HOLD_N_SIO3) begin
      state    <= state_n;
      cnt      <= cnt_n;
      shift_sr <= shift_n;
      addr     <= addr_n;
      is_read  <= is_read_n;
    end
  end

  // Mode register: only RESET and a completed WRMR byte change it.
  always_ff @(posedge SCK) begin
    if (RESET) begin
      mode <= MODE_RST;
    end else if (mode_we && HOLD_N_SIO3) begin
      mode <= shift_in;
    end
  end

  // Memory array: commit a write byte on the rise that samples its 8th bit.
  always_ff @(posedge SCK) begin
    if (mem_we && HOLD_N_SIO3 && !RESET) begin
      mem[addr] <= shift_in;
    end
  end

  // Falling-edge output stage: present the bit the master samples on the next rise.
  always_ff @(negedge SCK or posedge CS_N) begin
    if (CS_N) begin
      drive  <= 1'b0;
      so_bit <= 1'b0;
    end else if (HOLD_N_SIO3) begin
      drive  <= out_state;
      so_bit <= (state == ST_MODER) ? mode[bit_sel] : mem[addr][bit_sel];
    end
  end

  // Output enable also drops immediately on deselect, hold, or a state leaving the read phases.
  assign so_en   = drive && out_state && !CS_N && HOLD_N_SIO3;
  assign SO_SIO1 = so_en ? so_bit : 1'bz;

endmodule

// File: tb/tb_spi_sram_23lc512.sv
// Bench for spi_sram_23lc512: an SPI mode-0 master built from driver tasks,
// a byte-array reference memory with its own address-advance rules,
// and one task per scenario with inline comparisons.
module tb_spi_sram_23lc512;

  logic       sck = 1'b0;
  logic       reset = 1'b0;
  logic       cs_n = 1'b1;
  logic       si = 1'b0;
  logic       hold_n = 1'b1;
  wire        so;
  logic [2:0] dbg_state;
  logic       so_en;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] ref_mem [0:65535];
  logic [7:0] ref_mode;
  logic [7:0] wbuf[$];
  logic [7:0] rbuf[$];
  logic [7:0] exp_q[$];
  logic       en_seen;
  logic       hdr_en_seen;

  spi_sram_23lc512 dut (
    .SCK(sck),
    .RESET(reset),
    .CS_N(cs_n),
    .SI_SIO0(si),
    .SO_SIO1(so),
    .HOLD_N_SIO3(hold_n),
    .dbg_state(dbg_state),
    .so_en(so_en)
  );

  // clock / reset block
  always #5 sck = ~sck;

  task automatic apply_reset();
    @(negedge sck); #1;
    reset = 1'b1;
    @(negedge sck); @(negedge sck); #1;
    reset = 1'b0;
    ref_mode = 8'h40;
  endtask

  // reference model: address advance straight from the mode rules
  function automatic logic [15:0] model_next(input logic [15:0] a);
    int ai;
    ai = int'(a);
    case (ref_mode[7:6])
      2'b01:   return 16'((ai + 1) % 65536);
      2'b10:   return 16'((ai / 32) * 32 + ((ai % 32) + 1) % 32);
      default: return a;
    endcase
  endfunction

  task automatic model_write(input logic [15:0] a);
    logic [15:0] p;
    p = a;
    foreach (wbuf[i]) begin
      ref_mem[p] = wbuf[i];
      p = model_next(p);
    end
  endtask

  task automatic model_expect(input logic [15:0] a, input int n);
    logic [15:0] p;
    p = a;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ref_mem[p]);
      p = model_next(p);
    end
  endtask

  // driver tasks: every task starts and ends 1 time unit after a falling edge
  task automatic xfer_bit(input logic b, output logic o);
    si = b;
    #2;
    o = so;
    if (so_en) en_seen = 1'b1;
    @(negedge sck); #1;
  endtask

  task automatic xfer_byte(input logic [7:0] b, output logic [7:0] o);
    logic ob;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(b[i], ob);
      o[i] = ob;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    en_seen = 1'b0;
  endtask

  task automatic cs_end();
    cs_n = 1'b1;
    @(negedge sck); #1;
  endtask

  task automatic do_write(input logic [15:0] a);
    logic [7:0] o;
    cs_begin();
    xfer_byte(8'h02, o);
    xfer_byte(a[15:8], o);
    xfer_byte(a[7:0], o);
    foreach (wbuf[i]) xfer_byte(wbuf[i], o);
    cs_end();
    model_write(a);
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    logic [7:0] o;
    cs_begin();
    xfer_byte(8'h03, o);
    xfer_byte(a[15:8], o);
    xfer_byte(a[7:0], o);
    hdr_en_seen = en_seen;
    rbuf.delete();
    for (int i = 0; i < n; i++) begin
      xfer_byte(8'h00, o);
      rbuf.push_back(o);
    end
    cs_end();
    model_expect(a, n);
  endtask

  task automatic do_wrmr(input logic [7:0] m);
    logic [7:0] o;
    cs_begin();
    xfer_byte(8'h01, o);
    xfer_byte(m, o);
    cs_end();
    ref_mode = m;
  endtask

  task automatic do_rdmr(input int n);
    logic [7:0] o;
    cs_begin();
    xfer_byte(8'h05, o);
    hdr_en_seen = en_seen;
    rbuf.delete();
    for (int i = 0; i < n; i++) begin
      xfer_byte(8'h00, o);
      rbuf.push_back(o);
    end
    cs_end();
  endtask

  task automatic fill_wbuf(input int n);
    wbuf.delete();
    for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom_range(0, 255)));
  endtask

  // scenarios
  task automatic test_reset();
    apply_reset();
    vec_cnt++;
    if (so_en !== 1'b0) begin
      err_cnt++; $display("FAIL reset_idle_z: so_en=%b want 0", so_en);
    end
    vec_cnt++;
    if (dbg_state !== 3'd0) begin
      err_cnt++; $display("FAIL reset_state: state=%0d want 0 (IDLE)", dbg_state);
    end
    do_rdmr(2);
    vec_cnt++;
    if (hdr_en_seen !== 1'b0) begin
      err_cnt++; $display("FAIL rdmr_cmd_z: SO driven during command bits");
    end
    for (int i = 0; i < 2; i++) begin
      vec_cnt++;
      if (rbuf[i] !== 8'h40) begin
        err_cnt++; $display("FAIL rdmr_reset[%0d]: got %h want 40", i, rbuf[i]);
      end
    end
    vec_cnt++;
    if (so_en !== 1'b0) begin
      err_cnt++; $display("FAIL rdmr_after_cs_z: so_en=%b want 0", so_en);
    end
  endtask

  task automatic test_seq_rw();
    logic [15:0] a;
    int n;
    wbuf = '{8'hA5, 8'h5A, 8'hC3};
    do_write(16'h1234);
    vec_cnt++;
    if (en_seen !== 1'b0) begin
      err_cnt++; $display("FAIL write_z: SO driven during WRITE");
    end
    do_read(16'h1234, 3);
    vec_cnt++;
    if (hdr_en_seen !== 1'b0) begin
      err_cnt++; $display("FAIL read_hdr_z: SO driven before data phase");
    end
    exp_q = '{8'hA5, 8'h5A, 8'hC3};
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (rbuf[i] !== exp_q[i]) begin
        err_cnt++; $display("FAIL seq_fixed[%0d]: got %h want %h", i, rbuf[i], exp_q[i]);
      end
    end
    repeat (4) begin
      a = 16'($urandom_range(0, 65535));
      n = int'($urandom_range(1, 6));
      fill_wbuf(n);
      do_write(a);
      do_read(a, n);
      for (int i = 0; i < n; i++) begin
        vec_cnt++;
        if (rbuf[i] !== exp_q[i]) begin
          err_cnt++; $display("FAIL seq_rand @%h[%0d]: got %h want %h", a, i, rbuf[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_seq_wrap();
    wbuf = '{8'h11, 8'h22};
    do_write(16'hFFFF);
    do_read(16'hFFFF, 2);
    for (int i = 0; i < 2; i++) begin
      vec_cnt++;
      if (rbuf[i] !== exp_q[i] || rbuf[i] !== wbuf[i]) begin
        err_cnt++; $display("FAIL wrap_rd[%0d]: got %h want %h", i, rbuf[i], wbuf[i]);
      end
    end
    do_read(16'h0000, 1);
    vec_cnt++;
    if (rbuf[0] !== 8'h22) begin
      err_cnt++; $display("FAIL wrap_zero: got %h want 22", rbuf[0]);
    end
  endtask

  task automatic test_page_mode();
    logic [15:0] a;
    int n;
    do_wrmr(8'h80);
    wbuf = '{8'h77, 8'h88};
    do_write(16'h001F);
    do_read(16'h0000, 1);
    vec_cnt++;
    if (rbuf[0] !== 8'h88) begin
      err_cnt++; $display("FAIL page_wrap: got %h want 88", rbuf[0]);
    end
    do_read(16'h001F, 1);
    vec_cnt++;
    if (rbuf[0] !== 8'h77) begin
      err_cnt++; $display("FAIL page_1f: got %h want 77", rbuf[0]);
    end
    do_rdmr(1);
    vec_cnt++;
    if (rbuf[0] !== 8'h80) begin
      err_cnt++; $display("FAIL page_rdmr: got %h want 80", rbuf[0]);
    end
    repeat (3) begin
      a = 16'($urandom_range(0, 65535));
      n = int'($urandom_range(2, 40));
      fill_wbuf(n);
      do_write(a);
      do_read(a, n);
      for (int i = 0; i < n; i++) begin
        vec_cnt++;
        if (rbuf[i] !== exp_q[i]) begin
          err_cnt++; $display("FAIL page_rand @%h[%0d]: got %h want %h", a, i, rbuf[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_byte_mode();
    do_wrmr(8'h00);
    wbuf = '{8'h01, 8'h02};
    do_write(16'h0100);
    do_read(16'h0100, 3);
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (rbuf[i] !== 8'h02 || exp_q[i] !== 8'h02) begin
        err_cnt++; $display("FAIL byte_mode[%0d]: got %h want 02", i, rbuf[i]);
      end
    end
    // WRMR ignores bits past the 8th: 0x40 then junk leaves 0x40
    begin
      logic [7:0] o;
      cs_begin();
      xfer_byte(8'h01, o);
      xfer_byte(8'h40, o);
      xfer_byte(8'hC0, o);
      cs_end();
      ref_mode = 8'h40;
    end
    do_rdmr(1);
    vec_cnt++;
    if (rbuf[0] !== 8'h40) begin
      err_cnt++; $display("FAIL wrmr_extra: got %h want 40", rbuf[0]);
    end
  endtask

  task automatic test_abort_hold();
    logic [7:0]  o;
    logic [7:0]  byte_v;
    logic [15:0] a;
    logic        ob;
    int          hpos;
    wbuf = '{8'h3C};
    do_write(16'h0200);
    // partial byte then deselect
    cs_begin();
    xfer_byte(8'h02, o);
    xfer_byte(8'h02, o);
    xfer_byte(8'h00, o);
    for (int i = 0; i < 4; i++) xfer_bit(1'b1, ob);
    cs_end();
    do_read(16'h0200, 1);
    vec_cnt++;
    if (rbuf[0] !== 8'h3C || exp_q[0] !== 8'h3C) begin
      err_cnt++; $display("FAIL abort_partial: got %h want 3C", rbuf[0]);
    end
    // unknown opcode never drives SO
    cs_begin();
    xfer_byte(8'h9F, o);
    xfer_byte(8'h00, o);
    xfer_byte(8'h00, o);
    cs_end();
    vec_cnt++;
    if (en_seen !== 1'b0) begin
      err_cnt++; $display("FAIL unknown_op_z: SO driven after opcode 9F");
    end
    // hold for 5 SCK in the middle of a read
    a = 16'($urandom_range(0, 65535));
    fill_wbuf(4);
    do_write(a);
    model_expect(a, 4);
    hpos = int'($urandom_range(1, 31));
    cs_begin();
    xfer_byte(8'h03, o);
    xfer_byte(a[15:8], o);
    xfer_byte(a[7:0], o);
    rbuf.delete();
    for (int b = 0; b < 4; b++) begin
      for (int i = 7; i >= 0; i--) begin
        if (b * 8 + (7 - i) == hpos) begin
          hold_n = 1'b0;
          #1;
          vec_cnt++;
          if (so_en !== 1'b0) begin
            err_cnt++; $display("FAIL hold_z: so_en=%b want 0", so_en);
          end
          repeat (5) @(negedge sck);
          #1;
          hold_n = 1'b1;
        end
        xfer_bit(1'b0, ob);
        byte_v[i] = ob;
      end
      rbuf.push_back(byte_v);
    end
    cs_end();
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (rbuf[i] !== exp_q[i]) begin
        err_cnt++; $display("FAIL hold_rd @%h bit%0d [%0d]: got %h want %h", a, hpos, i, rbuf[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] o;
    logic       ob;
    // RESET on the same rise as the first selected edge: that edge is not a command bit
    do_wrmr(8'h00);
    cs_begin();
    si = 1'b1;
    reset = 1'b1;
    @(negedge sck); #1;
    reset = 1'b0;
    ref_mode = 8'h40;
    xfer_byte(8'h05, o);
    xfer_byte(8'h00, o);
    cs_end();
    vec_cnt++;
    if (o !== 8'h40) begin
      err_cnt++; $display("FAIL reset_collide_rdmr: got %h want 40", o);
    end
    // RESET mid-write drops the partial byte and restores the mode register
    wbuf = '{8'h99};
    do_write(16'h0300);
    do_wrmr(8'h80);
    cs_begin();
    xfer_byte(8'h02, o);
    xfer_byte(8'h03, o);
    xfer_byte(8'h00, o);
    for (int i = 0; i < 4; i++) xfer_bit(1'b0, ob);
    reset = 1'b1;
    xfer_bit(1'b0, ob);
    reset = 1'b0;
    cs_end();
    ref_mode = 8'h40;
    do_read(16'h0300, 1);
    vec_cnt++;
    if (rbuf[0] !== exp_q[0]) begin
      err_cnt++; $display("FAIL reset_mid_write: got %h want %h", rbuf[0], exp_q[0]);
    end
    do_rdmr(1);
    vec_cnt++;
    if (rbuf[0] !== 8'h40) begin
      err_cnt++; $display("FAIL reset_mode_restore: got %h want 40", rbuf[0]);
    end
  endtask

  initial begin
    ref_mode = 8'h40;
    en_seen = 1'b0;
    hdr_en_seen = 1'b0;
    test_reset();
    test_seq_rw();
    test_seq_wrap();
    test_page_mode();
    test_byte_mode();
    test_abort_hold();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
